// File: rtl/frame_pkg.sv
// frame_pkg: frame constants, state encoding and the CRC-16 word step shared with the parser
package frame_pkg;
    localparam logic [15:0] HDR_WORD  = 16'hE0E0;
    localparam logic [15:0] TAIL_WORD = 16'h0E0E;
    localparam logic [15:0] IDLE_WORD = 16'h0000;
    localparam logic [15:0] CRC_POLY  = 16'h1021;
    localparam logic [15:0] CRC_INIT  = 16'hFFFF;
    localparam logic [3:0]  MAX_LEN   = 4'd8;
    typedef enum logic [2:0] {IDLE, HDR, CH, LEN, PAY, CRC, TAIL} state_t;
    function automatic logic [15:0] crc16_step(input logic [15:0] c, input logic [15:0] d);
        logic [15:0] r;
        r = c;
        for (int i = 15; i >= 0; i--) r = {r[14:0], 1'b0} ^ ((r[15] ^ d[i]) ? CRC_POLY : 16'h0000);
        return r;
    endfunction
endpackage

// File: rtl/crc16_word_step.sv
// crc16_word_step: one 16-bit MSB-first CRC-16 update
module crc16_word_step
    import frame_pkg::*;
(
    input  logic [15:0] crc_in,
    input  logic [15:0] data,
    output logic [15:0] crc_out
);
    assign crc_out = crc16_step(crc_in, data);
endmodule

// File: rtl/frame_tx.sv
// frame_tx: emits HDR, CH, LEN, payload, CRC and TAIL words for one captured frame request
module frame_tx
    import frame_pkg::*;
(
    input  logic         clk_in,
    input  logic         rst,
    input  logic         start,
    input  logic [7:0]   vld_ch_i,
    input  logic [3:0]   len_i,
    input  logic [127:0] payload_i,
    input  logic         crc_corrupt_i,
    output logic [15:0]  data_out,
    output logic         data_out_vld,
    output logic         busy,
    output logic         done,
    output logic         len_err
);
    state_t         r_state;
    logic [7:0]     r_vld_ch;
    logic [3:0]     r_len;
    logic [127:0]   r_payload;
    logic           r_corrupt;
    logic [3:0]     r_cnt;
    logic [15:0]    r_crc;
    logic [15:0]    r_data;
    logic           r_vld;
    logic           r_busy;
    logic           r_done;
    logic           r_len_err;
    logic [15:0]    w_words [8];
    logic [2:0]     w_pay_idx;
    logic [15:0]    w_crc_data;
    logic [15:0]    w_crc_out;
    logic           w_last;
    logic           w_len_ok;

    always_comb begin
        for (int k = 0; k < 8; k++) w_words[k] = r_payload[127-16*k -: 16];
    end

    // w_crc_data is the word about to be emitted; it feeds both data_out and the CRC
    assign w_pay_idx  = (r_state == PAY) ? r_cnt[2:0] + 3'd1 : 3'd0;
    assign w_crc_data = (r_state == HDR) ? {8'h00, r_vld_ch} :
                        (r_state == CH)  ? {12'h000, r_len}  : w_words[w_pay_idx];
    assign w_last     = r_cnt == r_len - 4'd1;
    assign w_len_ok   = (len_i != 4'd0) && (len_i <= MAX_LEN);

    crc16_word_step u_crc (
        .crc_in  (r_crc),
        .data    (w_crc_data),
        .crc_out (w_crc_out)
    );

    always_ff @(posedge clk_in) begin
        if (rst) begin
            r_state   <= IDLE;
            r_vld_ch  <= '0;
            r_len     <= '0;
            r_payload <= '0;
            r_corrupt <= 1'b0;
            r_cnt     <= '0;
            r_crc     <= CRC_INIT;
            r_data    <= IDLE_WORD;
            r_vld     <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_len_err <= 1'b0;
        end else begin
            r_done    <= 1'b0;
            r_len_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_data <= IDLE_WORD;
                    r_vld  <= 1'b0;
                    r_busy <= 1'b0;
                    if (start && w_len_ok) begin
                        r_vld_ch  <= vld_ch_i;
                        r_len     <= len_i;
                        r_payload <= payload_i;
                        r_corrupt <= crc_corrupt_i;
                        r_crc     <= CRC_INIT;
                        r_state   <= HDR;
                        r_data    <= HDR_WORD;
                        r_vld     <= 1'b1;
                        r_busy    <= 1'b1;
                    end else if (start) begin
                        r_len_err <= 1'b1;
                    end
                end
                HDR, CH: begin
                    r_state <= (r_state == HDR) ? CH : LEN;
                    r_data  <= w_crc_data;
                    r_crc   <= w_crc_out;
                end
                LEN: begin
                    r_state <= PAY;
                    r_data  <= w_crc_data;
                    r_crc   <= w_crc_out;
                    r_cnt   <= '0;
                end
                PAY: begin
                    if (w_last) begin
                        r_state <= CRC;
                        r_data  <= r_crc ^ {15'd0, r_corrupt};
                    end else begin
                        r_cnt  <= r_cnt + 4'd1;
                        r_data <= w_crc_data;
                        r_crc  <= w_crc_out;
                    end
                end
                CRC: begin
                    r_state <= TAIL;
                    r_data  <= TAIL_WORD;
                    r_done  <= 1'b1;
                end
                TAIL: begin
                    r_state <= IDLE;
                    r_data  <= IDLE_WORD;
                    r_vld   <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign data_out     = r_data;
    assign data_out_vld = r_vld;
    assign busy         = r_busy;
    assign done         = r_done;
    assign len_err      = r_len_err;
endmodule

// File: tb/tb_frame_tx.sv
// tb_frame_tx: directed frames checked every cycle against a word-queue frame model
module tb_frame_tx;
    logic         clk_in = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [7:0]   vld_ch_i = '0;
    logic [3:0]   len_i = '0;
    logic [127:0] payload_i = '0;
    logic         crc_corrupt_i = 1'b0;
    logic [15:0]  data_out;
    logic         data_out_vld;
    logic         busy;
    logic         done;
    logic         len_err;

    frame_tx dut (
        .clk_in        (clk_in),
        .rst           (rst),
        .start         (start),
        .vld_ch_i      (vld_ch_i),
        .len_i         (len_i),
        .payload_i     (payload_i),
        .crc_corrupt_i (crc_corrupt_i),
        .data_out      (data_out),
        .data_out_vld  (data_out_vld),
        .busy          (busy),
        .done          (done),
        .len_err       (len_err)
    );

    always #5 clk_in = ~clk_in;

    typedef struct packed {
        logic [15:0] d;
        logic        v;
        logic        b;
        logic        dn;
        logic        le;
    } rec_t;

    rec_t        cur = '0;
    rec_t        exp_q[$];
    logic [15:0] rx_q[$];
    int          gaps_q[$];
    int          n_chk = 0, n_fail = 0;
    bit          chk_en = 1'b0;
    int          busy_cnt = 0, le_cnt = 0, vld_cnt = 0, dn_cnt = 0, idle_run = 0;
    logic [15:0] crc_a;

    function automatic logic [15:0] crc_bytes(input logic [7:0] m[$]);
        logic [15:0] c;
        logic        fb;
        c = 16'hFFFF;
        foreach (m[i]) begin
            for (int b = 7; b >= 0; b--) begin
                fb = c[15] ^ m[i][b];
                c  = c << 1;
                if (fb) c = c ^ 16'h1021;
            end
        end
        return c;
    endfunction

    function automatic logic [15:0] crc_words(input logic [15:0] w[$]);
        logic [7:0] bq[$];
        foreach (w[i]) begin
            bq.push_back(w[i][15:8]);
            bq.push_back(w[i][7:0]);
        end
        return crc_bytes(bq);
    endfunction

    function automatic logic parser_crc_err(input logic [15:0] f[$]);
        logic [15:0] body[$];
        if (f.size() < 6) return 1'b1;
        for (int i = 1; i < f.size() - 2; i++) body.push_back(f[i]);
        return crc_words(body) != f[f.size()-2];
    endfunction

    task automatic push_frame(input logic [7:0] v, input logic [3:0] n, input logic [127:0] p, input logic cc);
        logic [15:0] body[$];
        logic [15:0] fr[$];
        body.push_back({8'h00, v});
        body.push_back({12'h000, n});
        for (int k = 0; k < int'(n); k++) body.push_back(p[127-16*k -: 16]);
        fr.push_back(16'hE0E0);
        foreach (body[i]) fr.push_back(body[i]);
        fr.push_back(crc_words(body) ^ {15'd0, cc});
        fr.push_back(16'h0E0E);
        foreach (fr[i]) exp_q.push_back('{d: fr[i], v: 1'b1, b: 1'b1, dn: i == fr.size() - 1, le: 1'b0});
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // model: a frame is accepted only when nothing was being sent in the current cycle
    always @(posedge clk_in) begin
        if (rst) begin
            exp_q.delete();
            cur = '0;
        end else if (exp_q.size() > 0) begin
            cur = exp_q.pop_front();
        end else if (!cur.v && start) begin
            if (len_i >= 4'd1 && len_i <= 4'd8) begin
                push_frame(vld_ch_i, len_i, payload_i, crc_corrupt_i);
                cur = exp_q.pop_front();
            end else begin
                cur = '{d: 16'h0000, v: 1'b0, b: 1'b0, dn: 1'b0, le: 1'b1};
            end
        end else begin
            cur = '0;
        end
    end

    always @(negedge clk_in) begin
        if (chk_en) begin
            check("cycle {data,vld,busy,done,len_err}", {12'd0, data_out, data_out_vld, busy, done, len_err}, {12'd0, cur});
            if (data_out_vld) rx_q.push_back(data_out);
            busy_cnt += int'(busy);
            le_cnt   += int'(len_err);
            vld_cnt  += int'(data_out_vld);
            dn_cnt   += int'(done);
            if (data_out_vld) begin
                if (idle_run > 0) gaps_q.push_back(idle_run);
                idle_run = 0;
            end else begin
                idle_run++;
            end
        end
    end

    task automatic clr();
        rx_q.delete();
        gaps_q.delete();
        busy_cnt = 0;
        le_cnt   = 0;
        vld_cnt  = 0;
        dn_cnt   = 0;
    endtask

    task automatic send(input logic [7:0] v, input logic [3:0] n, input logic [127:0] p, input logic cc);
        @(negedge clk_in);
        vld_ch_i      = v;
        len_i         = n;
        payload_i     = p;
        crc_corrupt_i = cc;
        start         = 1'b1;
        @(negedge clk_in);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int k;
        k = 0;
        while (!done && k < budget) begin
            @(negedge clk_in);
            k++;
        end
        check("done seen", {31'd0, done}, 32'd1);
        @(negedge clk_in);
    endtask

    localparam logic [127:0] P_A = {16'h1234, 16'hABCD, 96'd0};
    localparam logic [127:0] P_B = 128'h0001_0002_0003_0004_0005_0006_0007_0008;

    initial begin
        logic [7:0]  bq[$];
        logic [15:0] wq[$];
        @(negedge clk_in);
        chk_en = 1'b1;
        check("reset outputs", {12'd0, data_out, data_out_vld, busy, done, len_err}, 32'd0);
        bq = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        check("model crc of 123456789", {16'd0, crc_bytes(bq)}, 32'h29B1);
        @(negedge clk_in);
        rst = 1'b0;

        clr();
        send(8'h81, 4'd2, P_A, 1'b0);
        wait_done(20);
        wq = '{16'h0081, 16'h0002, 16'h1234, 16'hABCD};
        check("A length", rx_q.size(), 7);
        check("A hdr", {16'd0, rx_q[0]}, 32'hE0E0);
        check("A ch", {16'd0, rx_q[1]}, 32'h0081);
        check("A len", {16'd0, rx_q[2]}, 32'h0002);
        check("A w0", {16'd0, rx_q[3]}, 32'h1234);
        check("A w1", {16'd0, rx_q[4]}, 32'hABCD);
        check("A crc", {16'd0, rx_q[5]}, {16'd0, crc_words(wq)});
        check("A tail", {16'd0, rx_q[6]}, 32'h0E0E);
        check("A parser crc_err", {31'd0, parser_crc_err(rx_q)}, 32'd0);
        check("A busy cycles", busy_cnt, 7);
        crc_a = rx_q[5];

        clr();
        send(8'h3C, 4'd8, P_B, 1'b0);
        wait_done(30);
        check("B length", rx_q.size(), 13);
        check("B busy cycles", busy_cnt, 13);
        check("B first payload", {16'd0, rx_q[3]}, 32'h0001);
        check("B last payload", {16'd0, rx_q[10]}, 32'h0008);
        check("B parser crc_err", {31'd0, parser_crc_err(rx_q)}, 32'd0);
        check("B done count", dn_cnt, 1);

        clr();
        send(8'hFF, 4'd0, P_B, 1'b0);
        repeat (3) @(negedge clk_in);
        send(8'hFF, 4'd9, P_B, 1'b0);
        repeat (3) @(negedge clk_in);
        check("len_err pulses", le_cnt, 2);
        check("len_err vld cycles", vld_cnt, 0);
        check("len_err busy cycles", busy_cnt, 0);

        clr();
        send(8'h81, 4'd2, P_A, 1'b1);
        wait_done(20);
        check("D corrupted crc", {16'd0, rx_q[5]}, {16'd0, crc_a ^ 16'h0001});
        check("D parser crc_err", {31'd0, parser_crc_err(rx_q)}, 32'd1);

        clr();
        send(8'h5A, 4'd8, P_B, 1'b0);
        repeat (5) @(negedge clk_in);
        check("E third payload on wire", {16'd0, data_out}, 32'h0003);
        rst = 1'b1;
        @(negedge clk_in);
        check("E after rst", {12'd0, data_out, data_out_vld, busy, done, len_err}, 32'd0);
        rst = 1'b0;
        repeat (12) @(negedge clk_in);
        check("E no done after abort", dn_cnt, 0);
        clr();
        send(8'h81, 4'd2, P_A, 1'b0);
        wait_done(20);
        check("E fresh crc", {16'd0, rx_q[5]}, {16'd0, crc_a});
        check("E fresh parser crc_err", {31'd0, parser_crc_err(rx_q)}, 32'd0);

        clr();
        @(negedge clk_in);
        len_i     = 4'd1;
        payload_i = {16'hC0DE, 112'd0};
        vld_ch_i  = 8'h11;
        start     = 1'b1;
        for (int i = 0; i < 21; i++) begin
            @(negedge clk_in);
            vld_ch_i  = 8'(i * 7);
            payload_i = {16'(i * 16'h0101), 112'd0};
        end
        start = 1'b0;
        repeat (3) @(negedge clk_in);
        check("F frames", dn_cnt, 3);
        check("F vld cycles", vld_cnt, 18);
        check("F gap count", gaps_q.size(), 3);
        check("F gap 1", gaps_q[1], 1);
        check("F gap 2", gaps_q[2], 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
